ext_bus_initiator: RTL and testbench

EXT_BUS_INITIATOR -- requirements
Module: ext_bus_initiator

---
 rtl/ext_bus_initiator.sv | 170 +++++++++++++++++
 tb/tb_ext_bus_initiator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_initiator.sv
// rtl/ext_bus_initiator.sv - strobed external bus initiator with programmable lead/active/trail timing
//
// Parameters:
//   LEAD_CYC   (1..15) cycles with cs_n low before the strobe asserts
//   ACTIVE_CYC (1..15) cycles with re_n or we_n low
//   TRAIL_CYC  (1..15) cycles with cs_n low after the strobe releases
// Ports:
//   xclk        in   bus clock, rising edge
//   cpld_reset  in   asynchronous active-low reset
//   req         in   transaction request, sampled only while idle
//   rnw         in   1 = read, 0 = write
//   addr        in   [7:0]  target address
//   wdata       in   [15:0] write data
//   busy        out  transaction in progress
//   done        out  one-cycle completion pulse
//   rdata       out  [15:0] last captured read data
//   cs_n        out  chip select, active-low
//   re_n        out  read enable, active-low
//   we_n        out  write enable, active-low
//   ab          out  [7:0]  bus address
//   db_out      out  [15:0] data driven onto the bus
//   db_oe       out  data bus drive enable (tristate buffer lives in the parent)
//   db_in       in   [15:0] data sampled from the bus
module ext_bus_initiator #(
    parameter int LEAD_CYC   = 2,
    parameter int ACTIVE_CYC = 3,
    parameter int TRAIL_CYC  = 1
) (
    input  logic        xclk,
    input  logic        cpld_reset,
    input  logic        req,
    input  logic        rnw,
    input  logic [7:0]  addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        cs_n,
    output logic        re_n,
    output logic        we_n,
    output logic [7:0]  ab,
    output logic [15:0] db_out,
    output logic        db_oe,
    input  logic [15:0] db_in
);

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        ACTIVE,
        TRAIL
    } state_t;

    // The counter is loaded with N-1 on entry and the phase ends on the
    // edge where it reads zero, so a phase lasts exactly N cycles and the
    // counter only ever counts down to zero (never wraps).
    localparam logic [3:0] LEAD_LD   = 4'(LEAD_CYC - 1);
    localparam logic [3:0] ACTIVE_LD = 4'(ACTIVE_CYC - 1);
    localparam logic [3:0] TRAIL_LD  = 4'(TRAIL_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rnw_q, rnw_d;

    logic        busy_d, done_d, cs_n_d, re_n_d, we_n_d, db_oe_d;
    logic [15:0] rdata_d, db_out_d;
    logic [7:0]  ab_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rnw_d    = rnw_q;
        busy_d   = busy;
        done_d   = 1'b0;
        rdata_d  = rdata;
        cs_n_d   = cs_n;
        re_n_d   = re_n;
        we_n_d   = we_n;
        ab_d     = ab;
        db_out_d = db_out;
        db_oe_d  = db_oe;

        case (state_q)
            IDLE: begin
                if (req) begin
                    // Latch the whole request here; later input changes
                    // cannot reach the bus until the next IDLE.
                    state_d  = LEAD;
                    cnt_d    = LEAD_LD;
                    rnw_d    = rnw;
                    busy_d   = 1'b1;
                    cs_n_d   = 1'b0;
                    ab_d     = addr;
                    db_out_d = wdata;
                    db_oe_d  = ~rnw;
                end
            end
            LEAD: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACTIVE;
                    cnt_d   = ACTIVE_LD;
                    re_n_d  = ~rnw_q;
                    we_n_d  = rnw_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACTIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d = TRAIL;
                    cnt_d   = TRAIL_LD;
                    re_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    if (rnw_q) begin
                        rdata_d = db_in;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            TRAIL: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cs_n_d  = 1'b1;
                    db_oe_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge xclk or negedge cpld_reset) begin
        if (!cpld_reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rnw_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= 16'h0000;
            cs_n    <= 1'b1;
            re_n    <= 1'b1;
            we_n    <= 1'b1;
            ab      <= 8'h00;
            db_out  <= 16'h0000;
            db_oe   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnw_q   <= rnw_d;
            busy    <= busy_d;
            done    <= done_d;
            rdata   <= rdata_d;
            cs_n    <= cs_n_d;
            re_n    <= re_n_d;
            we_n    <= we_n_d;
            ab      <= ab_d;
            db_out  <= db_out_d;
            db_oe   <= db_oe_d;
        end
    end

endmodule

// File: tb/tb_ext_bus_initiator.sv
// tb/tb_ext_bus_initiator.sv - self-checking bench for ext_bus_initiator
module tb_ext_bus_initiator;

    logic        xclk = 1'b0;
    logic        cpld_reset;
    logic        req, req2;
    logic        rnw;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] db_in;

    logic        busy, done, cs_n, re_n, we_n, db_oe;
    logic [15:0] rdata, db_out;
    logic [7:0]  ab;

    logic        busy2, done2, cs_n2, re_n2, we_n2, db_oe2;
    logic [15:0] rdata2, db_out2;
    logic [7:0]  ab2;

    int total  = 0;
    int passed = 0;

    always #5 xclk = ~xclk;

    ext_bus_initiator dut (
        .xclk(xclk), .cpld_reset(cpld_reset), .req(req), .rnw(rnw),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .cs_n(cs_n), .re_n(re_n), .we_n(we_n), .ab(ab), .db_out(db_out),
        .db_oe(db_oe), .db_in(db_in)
    );

    ext_bus_initiator #(.LEAD_CYC(1), .ACTIVE_CYC(15), .TRAIL_CYC(15)) dut_sweep (
        .xclk(xclk), .cpld_reset(cpld_reset), .req(req2), .rnw(rnw),
        .addr(addr), .wdata(wdata), .busy(busy2), .done(done2), .rdata(rdata2),
        .cs_n(cs_n2), .re_n(re_n2), .we_n(we_n2), .ab(ab2), .db_out(db_out2),
        .db_oe(db_oe2), .db_in(db_in)
    );

    typedef struct {
        logic        rnw;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] dbin;
        logic        perturb;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge xclk);
        #1;
    endtask

    // One default-timing transaction; k is the cycle index after request edge E0.
    task automatic run_txn(input vec_t v, input logic [15:0] prev_rdata);
        int ndone;
        ndone = 0;
        rnw   = v.rnw;
        addr  = v.addr;
        wdata = v.wdata;
        db_in = ~v.dbin;
        req   = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            tick();
            if (k == 0) req = 1'b0;
            if (v.perturb && k == 1) begin
                req   = 1'b1;
                addr  = 8'h55;
                wdata = ~v.wdata;
                rnw   = ~v.rnw;
            end
            if (v.perturb && k == 2) req = 1'b0;
            if (k == 2) db_in = v.dbin;
            if (k == 5) db_in = 16'hDEAD;
            if (done) ndone++;
            chk($sformatf("cs_n k%0d", k), cs_n, (k <= 5) ? 1'b0 : 1'b1);
            chk($sformatf("re_n k%0d", k), re_n, (v.rnw && k >= 2 && k <= 4) ? 1'b0 : 1'b1);
            chk($sformatf("we_n k%0d", k), we_n, (!v.rnw && k >= 2 && k <= 4) ? 1'b0 : 1'b1);
            chk($sformatf("db_oe k%0d", k), db_oe, (!v.rnw && k <= 5) ? 1'b1 : 1'b0);
            chk($sformatf("busy k%0d", k), busy, (k <= 5) ? 1'b1 : 1'b0);
            chk($sformatf("done k%0d", k), done, (k == 6) ? 1'b1 : 1'b0);
            chk($sformatf("ab k%0d", k), ab, v.addr);
            if (!v.rnw && k <= 5) chk($sformatf("db_out k%0d", k), db_out, v.wdata);
            chk($sformatf("rdata k%0d", k), rdata, (k >= 5) ? v.exp_rdata : prev_rdata);
        end
        chk("done pulses", ndone, 1);
    endtask

    initial begin
        int cs_cnt, st_cnt, first_st, last_st, nd, ov;
        vec_t rv;

        vecs[0] = '{rnw: 1'b0, addr: 8'h12, wdata: 16'hA5C3, dbin: 16'h0000, perturb: 1'b0, exp_rdata: 16'h0000};
        vecs[1] = '{rnw: 1'b1, addr: 8'h34, wdata: 16'h1111, dbin: 16'h3C5A, perturb: 1'b0, exp_rdata: 16'h3C5A};
        vecs[2] = '{rnw: 1'b0, addr: 8'h12, wdata: 16'hA5C3, dbin: 16'h7777, perturb: 1'b1, exp_rdata: 16'h3C5A};
        vecs[3] = '{rnw: 1'b1, addr: 8'hFF, wdata: 16'h0F0F, dbin: 16'hFFFF, perturb: 1'b1, exp_rdata: 16'hFFFF};
        vecs[4] = '{rnw: 1'b0, addr: 8'h00, wdata: 16'h0001, dbin: 16'h8001, perturb: 1'b0, exp_rdata: 16'hFFFF};

        cpld_reset = 1'b0;
        req = 1'b1; req2 = 1'b1;
        rnw = 1'b0; addr = 8'hAA; wdata = 16'hBEEF; db_in = 16'h0000;
        tick(); tick(); tick();
        chk("rst cs_n", cs_n, 1'b1);
        chk("rst re_n", re_n, 1'b1);
        chk("rst we_n", we_n, 1'b1);
        chk("rst db_oe", db_oe, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst ab", ab, 8'h00);
        chk("rst db_out", db_out, 16'h0000);
        chk("rst rdata", rdata, 16'h0000);
        chk("rst cs_n2", cs_n2, 1'b1);
        req = 1'b0; req2 = 1'b0;
        cpld_reset = 1'b1;

        // Table-driven transactions; rdata model carries over between vectors.
        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i], (i == 0) ? 16'h0000 : vecs[i-1].exp_rdata);
        end

        // Back-to-back with req held high: second start at E7.
        rnw = 1'b0; addr = 8'h12; wdata = 16'hA5C3; req = 1'b1;
        for (int k = 0; k <= 14; k++) begin
            tick();
            if (k == 8) req = 1'b0;
            chk($sformatf("b2b cs_n k%0d", k), cs_n, (k <= 5 || (k >= 7 && k <= 12)) ? 1'b0 : 1'b1);
            chk($sformatf("b2b done k%0d", k), done, (k == 6 || k == 13) ? 1'b1 : 1'b0);
        end

        // Reset during ACTIVE of a write.
        rnw = 1'b0; addr = 8'h66; wdata = 16'h5A5A; req = 1'b1;
        tick(); req = 1'b0;
        tick(); tick(); tick();
        chk("mid we_n before", we_n, 1'b0);
        cpld_reset = 1'b0;
        #1;
        chk("mid cs_n", cs_n, 1'b1);
        chk("mid we_n", we_n, 1'b1);
        chk("mid db_oe", db_oe, 1'b0);
        chk("mid busy", busy, 1'b0);
        chk("mid ab", ab, 8'h00);
        chk("mid rdata", rdata, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mid done %0d", k), done, 1'b0);
        end
        cpld_reset = 1'b1;
        rv = '{rnw: 1'b1, addr: 8'h21, wdata: 16'h1234, dbin: 16'hC001, perturb: 1'b0, exp_rdata: 16'hC001};
        run_txn(rv, 16'h0000);

        // Parameter sweep: LEAD=1, ACTIVE=15, TRAIL=15 write.
        cs_cnt = 0; st_cnt = 0; first_st = -1; last_st = -1; nd = 0; ov = 0;
        rnw = 1'b0; addr = 8'h77; wdata = 16'h0BAD; req2 = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 0) req2 = 1'b0;
            if (!cs_n2) cs_cnt++;
            if (!we_n2) begin
                st_cnt++;
                if (first_st < 0) first_st = k;
                last_st = k;
            end
            if (done2) nd++;
            if ((!we_n2 && !re_n2) || (cs_n2 && (!we_n2 || !re_n2))) ov++;
        end
        chk("sweep cs_n low", cs_cnt, 31);
        chk("sweep we_n low", st_cnt, 15);
        chk("sweep strobe first", first_st, 1);
        chk("sweep strobe last", last_st, 15);
        chk("sweep done", nd, 1);
        chk("sweep overlap", ov, 0);
        chk("sweep re_n idle", re_n2, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
